// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants, state encoding and search result type for the round-robin arbiter.
package mux8_rr_arbiter_pkg;

    localparam int unsigned NREQ = 8;
    localparam int unsigned SELW = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic            found;
        logic [SELW-1:0] idx;
    } pick_t;

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Requester/consumer bus of the arbiter: eight request lines and words in, one handshaked word out.
interface mux8_rr_arbiter_if #(
    parameter int unsigned W = 32
) ();
    import mux8_rr_arbiter_pkg::*;

    logic [NREQ-1:0] req;
    logic [W-1:0]    I0;
    logic [W-1:0]    I1;
    logic [W-1:0]    I2;
    logic [W-1:0]    I3;
    logic [W-1:0]    I4;
    logic [W-1:0]    I5;
    logic [W-1:0]    I6;
    logic [W-1:0]    I7;
    logic [NREQ-1:0] ack;
    logic [SELW-1:0] s;
    logic [W-1:0]    o;
    logic            o_valid;
    logic            o_ready;

    // Arbiter side
    modport slave (
        input  req, I0, I1, I2, I3, I4, I5, I6, I7, o_ready,
        output ack, s, o, o_valid
    );

    // Requesters plus consumer side
    modport master (
        output req, I0, I1, I2, I3, I4, I5, I6, I7, o_ready,
        input  ack, s, o, o_valid
    );

endinterface

// File: rtl/MUX8T1_32.sv
// 8-to-1 word multiplexer selecting one requester word by index.
module MUX8T1_32 #(
    parameter int unsigned W = 32
) (
    input  logic [2:0]   s,
    input  logic [W-1:0] I0,
    input  logic [W-1:0] I1,
    input  logic [W-1:0] I2,
    input  logic [W-1:0] I3,
    input  logic [W-1:0] I4,
    input  logic [W-1:0] I5,
    input  logic [W-1:0] I6,
    input  logic [W-1:0] I7,
    output logic [W-1:0] o
);

    // Pure select, no state
    always_comb begin
        o = I0;
        case (s)
            3'd0:    o = I0;
            3'd1:    o = I1;
            3'd2:    o = I2;
            3'd3:    o = I3;
            3'd4:    o = I4;
            3'd5:    o = I5;
            3'd6:    o = I6;
            3'd7:    o = I7;
            default: o = I0;
        endcase
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter: picks one of eight requesters, registers its word and offers it on valid/ready.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic               clk,
    input  logic               rst,
    mux8_rr_arbiter_if.slave   bus
);

    state_t          state;
    state_t          state_nx;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_nx;
    logic [SELW-1:0] s_q;
    logic [SELW-1:0] sel_nx;
    logic [W-1:0]    o_q;
    logic [W-1:0]    mux_o;
    logic            valid_q;
    logic            valid_nx;
    logic            load;
    logic [NREQ-1:0] ack_c;
    pick_t           pick;

    // First set bit of r at or after start, wrapping modulo NREQ
    function automatic pick_t rr_pick(input logic [NREQ-1:0] r, input logic [SELW-1:0] start);
        pick_t           res;
        logic [SELW-1:0] k;
        res = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = start + SELW'(i);
            if (!res.found && r[k]) begin
                res.found = 1'b1;
                res.idx   = k;
            end
        end
        return res;
    endfunction

    // Data selection follows the next-cycle select so the winner's word is captured at grant
    MUX8T1_32 #(.W(W)) u_mux (
        .s  (sel_nx),
        .I0 (bus.I0),
        .I1 (bus.I1),
        .I2 (bus.I2),
        .I3 (bus.I3),
        .I4 (bus.I4),
        .I5 (bus.I5),
        .I6 (bus.I6),
        .I7 (bus.I7),
        .o  (mux_o)
    );

    // Next state, grant search and same-cycle acknowledge
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        sel_nx   = s_q;
        valid_nx = valid_q;
        load     = 1'b0;
        ack_c    = '0;
        pick     = '0;
        case (state)
            IDLE: begin
                pick = rr_pick(bus.req, ptr);
                if (pick.found) begin
                    sel_nx   = pick.idx;
                    load     = 1'b1;
                    valid_nx = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (bus.o_ready) begin
                    ack_c  = NREQ'(1) << s_q;
                    ptr_nx = s_q + SELW'(1);
                    // Mask the index just served so a persistent requester cannot win twice in a row
                    pick   = rr_pick(bus.req & ~(NREQ'(1) << s_q), s_q + SELW'(1));
                    if (pick.found) begin
                        sel_nx = pick.idx;
                        load   = 1'b1;
                    end else begin
                        valid_nx = 1'b0;
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // A word dropped by reset is never acknowledged
        if (rst) begin
            ack_c = '0;
        end
    end

    // State, pointer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            s_q     <= '0;
            o_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            s_q     <= sel_nx;
            valid_q <= valid_nx;
            if (load) begin
                o_q <= mux_o;
            end
        end
    end

    assign bus.ack     = ack_c;
    assign bus.s       = s_q;
    assign bus.o       = o_q;
    assign bus.o_valid = valid_q;

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares one 32-bit output channel among eight requesters. It drives the select of an 8-to-1 32-bit multiplexer, captures the winning word into an output register, and presents it on a valid/ready handshake. Each requester receives a one-cycle acknowledge when its word is accepted downstream. It sits between the eight data sources and the single consumer in the Lab datapath.

## Interface

**Parameters**
- `W`, default 32: data width. The select width is fixed at 3 and the requester count at 8.

**Ports**
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  8  `req[k]` high means requester k has a word on `Ik`.
- `I0`..`I7`  in  W each  requester data words.
- `ack`  out  8  one-hot, one-cycle pulse; `ack[k]` means requester k's word was accepted.
- `s`  out  3  index of the current grant; drives the mux select.
- `o`  out  W  registered output word.
- `o_valid`  out  1  `o` holds an unaccepted word.
- `o_ready`  in  1  consumer accepts `o` this cycle.

## Operation

- Two states: IDLE and BUSY. A 3-bit priority pointer `ptr` is the first index searched; the search order is `ptr`, `ptr+1`, …, mod 8.
- **IDLE:** `o_valid=0`. If any `req` bit is set, pick the winner `w` by the rotating search. Then:
  - `s<=w`, `o<=Iw`, `o_valid<=1`
  - go to BUSY.
- **BUSY:** `o_valid=1`. `o` and `s` are held stable until a handshake.
- **Handshake** is `o_valid & o_ready`. On a handshake cycle:
  - `ack[s]=1` combinationally, in that same cycle.
  - `ptr<=s+1` (wraps 7→0).
  - Re-arbitrate over `req` with bit `s` masked off, searching from `s+1`.
    - If there is a winner: load it (`s`, `o`, `o_valid=1`) and stay in BUSY (back-to-back transfer).
    - Otherwise: `o_valid<=0` and go to IDLE.
- **Requester rules:**
  - Hold `req[k]` and `Ik` stable until `ack[k]`.
  - Data is captured at grant, so later changes to `Ik` or `req[k]` do not affect the captured word.
  - Deasserting `req[s]` while BUSY is ignored; the captured word still completes and is acked.
- **Fairness:** a requester that holds `req` continuously is served at most every other cycle when any other requester, or none, is pending. This follows from masking the just-acked index. With all eight requesting, grants rotate strictly 0→7.
- **Reset values:** `s=0`, `o=0`, `o_valid=0`, `ack=0`, `ptr=0`, state IDLE.
- **Reset mid-transfer:** the captured word is dropped with no `ack`. The first grant after reset searches from 0.
- **`o_ready` while `o_valid=0`:** no effect.

## Timing

- Latency from `req` to `o_valid` in IDLE: `req` sampled at edge t, `o_valid`/`o`/`s` valid after edge t (one cycle).
- `ack` is combinational from `o_ready` and the state registers. The consumer must not derive `o_ready` from `ack`.
- `o` and `s` change only on the edge following a handshake, or when leaving IDLE.
- Throughput: one word per cycle while `o_ready=1` and at least two distinct requesters are pending.
- `rst` has priority over every other event in the same cycle.

## Structure

- Shared package holds:
  - constant `NREQ=8`, `SELW=3`
  - state encoding `IDLE=1'b0`, `BUSY=1'b1`.
- Sub-module: the existing `MUX8T1_32` performs the data selection, driven by the next-state select value. The arbiter registers its output into `o`.
- The rotating-priority search (pointer plus mask to winner index and found flag) is a function or combinational block inside this module, not a separate module.

## Test plan

1. **Reset:** hold `rst=1` for 2 cycles with `req=8'hFF`, then release with `Ik=k` and `o_ready=1`.
   - During reset: `o_valid=0`, `s=0`, `o=0`, `ack=0`.
   - First grant after release: `s=0`, `o=0`.
2. **Full rotation:** `req=8'hFF` held, `Ik=k`, `o_ready=1` constantly.
   - `s`/`o` sequence 0,1,…,7,0 on consecutive cycles.
   - `ack` = `8'h01`, `8'h02`, …, `8'h80`, one per cycle.
3. **Backpressure:** `req=8'h04`, `I2=32'hDEADBEEF`, `o_ready=0` for 5 cycles.
   - `o_valid=1`, `o=32'hDEADBEEF`, `s=2`, `ack=0` throughout.
   - Then `o_ready=1`: `ack=8'h04` that cycle, `o_valid=0` next cycle.
4. **Wrap-around:** after a grant to index 6 completes, drive `req=8'h81` with `o_ready=1`.
   - Grant 7, then grant 0 back-to-back.
   - `ack` = `8'h80`, then `8'h01`.
5. **Single persistent requester:** `req=8'h08`, `o_ready=1`.
   - `o_valid` toggles 1,0,1,0.
   - `ack[3]` pulses every other cycle, and `s=3` throughout.
6. **Reset mid-transfer:** while BUSY with `s=5` and `o_ready=0`, assert `rst` for 1 cycle.
   - No `ack` pulse.
   - Next cycle: `o_valid=0`, `s=0`, `o=0`.
   - With `req=8'h20` still high, a grant to 5 follows one cycle after reset release.
